param_sync_counter: RTL and testbench
=====================================

Name: param_sync_counter

Overview:
Parametrised synchronous counter: WIDTH bits, programmable modulus, up/down, parallel load, enable, wrap-or-saturate, binary or Gray output coding.
Generalises the fixed 4-bit JK-sequenced counter into a reusable counting primitive for timers, dividers and sequencers.
Cascadable through a combinational terminal-count output.

Parameters:
WIDTH, 4, counter width in bits (2..32).
MAX_COUNT, 2**WIDTH-1, highest state; count range is 0..MAX_COUNT (modulus MAX_COUNT+1). Must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clock  in  1  rising-edge clock.
clear  in  1  asynchronous active-high reset.
sync_clear  in  1  synchronous clear to 0; highest synchronous priority.
enable  in  1  count enable.
up  in  1  direction: 1 = increment, 0 = decrement.
load  in  1  synchronous parallel load.
load_value  in  WIDTH  value to load.
gray_sel  in  1  output coding: 0 = binary, 1 = Gray.
q  out  WIDTH  registered count in the selected coding.
q_bar  out  WIDTH  bitwise inverse of q.
count_bin  out  WIDTH  registered binary count, regardless of gray_sel.
terminal  out  1  combinational: enable & ((up & count==MAX_COUNT) | (!up & count==0)).
wrap_pulse  out  1  registered one-cycle pulse; high the cycle after a wrap occurs.

Behaviour:
- Reset: clear=1 asynchronously forces count_bin=0, q=0, q_bar=all-ones, wrap_pulse=0. Effect is immediate, mid-count or mid-load. Release is synchronous to the next rising edge; the first operation happens on the first edge with clear=0.
- Synchronous priority per rising edge: sync_clear > load > enable > hold.
- sync_clear=1: count_bin <- 0; wrap_pulse <- 0.
- load=1: count_bin <- min(load_value, MAX_COUNT). Out-of-range values clamp to MAX_COUNT. enable and up are ignored that cycle. wrap_pulse <- 0.
- enable=1, up=1:
  - count < MAX_COUNT: count+1.
  - count == MAX_COUNT, SATURATE=0: count <- 0 and wrap_pulse <- 1.
  - count == MAX_COUNT, SATURATE=1: count holds and wrap_pulse <- 0.
- enable=1, up=0:
  - count > 0: count-1.
  - count == 0, SATURATE=0: count <- MAX_COUNT and wrap_pulse <- 1.
  - count == 0, SATURATE=1: count holds.
- enable=0 and no load or clear: count holds; wrap_pulse <- 0.
- Direction changes take effect on the edge where up is sampled; there is no pipeline.
- Output coding:
  - q is registered from the next-state value, so it is aligned with count_bin in the same cycle and has zero added latency.
  - gray_sel=1: q = next ^ (next >> 1). gray_sel=0: q = next.
  - Toggling gray_sel while holding changes q on the next edge only; q is never combinational.
- All arithmetic is WIDTH-bit. No intermediate overflow is permitted; comparisons happen before increment.
- terminal is combinational from registered count and live enable/up, for ripple-free cascading into the next stage's enable.

Decomposition:
- Shared counter package:
  - direction constants DIR_DOWN=0, DIR_UP=1.
  - coding constants CODE_BIN=0, CODE_GRAY=1.
  - function bin2gray(value).
- One sub-module, counter_next_state: combinational next-count plus wrap flag from count, enable, up, load, load_value, sync_clear and the parameters.
- Top level holds the registers, the output coding and terminal.

Test Plan:
- WIDTH=4, MAX_COUNT=9, SATURATE=0, up=1, enable=1 from reset: count_bin 0,1,..,9,0. terminal=1 while count=9. wrap_pulse=1 exactly in the cycle count shows 0.
- Same config, up=0 from 0: next count 9 with wrap_pulse=1, then 8,7... terminal=1 at count 0.
- SATURATE=1, MAX_COUNT=9, up=1 for 15 cycles: count sticks at 9 and wrap_pulse never asserts. With up=0 from 0, count stays 0.
- load=1, load_value=12, MAX_COUNT=9: count_bin=9. Same edge with enable=1 and sync_clear=1: count_bin=0 (sync_clear wins). load with enable: loaded value, no increment.
- gray_sel=1, WIDTH=4, MAX_COUNT=15, counting 7 -> 8: q goes 0100 -> 1100 with exactly one bit change per step. q_bar always equals ~q.
- Assert clear asynchronously between edges at count=5: q=0 immediately without a clock edge. After deassertion, the first enabled edge gives count_bin=1.

Source files
------------

// File: rtl/param_sync_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : param_sync_counter_pkg
// Brief  : Shared direction/coding constants and Gray helper for the counter.
// Rev    : 1.0  initial release
// ============================================================================
package param_sync_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic CODE_BIN  = 1'b0;
  localparam logic CODE_GRAY = 1'b1;

  // Callers truncate the result to their own width; upper bits stay zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_next_state.sv
`default_nettype none
// ============================================================================
// Module : counter_next_state
// Brief  : Combinational next count and wrap flag for param_sync_counter.
// Rev    : 1.0  initial release
// ============================================================================
module counter_next_state
  import param_sync_counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          SATURATE  = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sync_clear,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  logic w_at_max;
  logic w_at_zero;

  // Range-end tests are made on the current count so the +/-1 never overflows.
  assign w_at_max  = (count >= c_max);
  assign w_at_zero = (count == c_zero);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (sync_clear) begin
      next_count = c_zero;
    end else if (load) begin
      next_count = (load_value > c_max) ? c_max : load_value;
    end else if (enable) begin
      case (up)
        DIR_UP: begin
          if (!w_at_max) begin
            next_count = count + c_one;
          end else if (SATURATE == 0) begin
            next_count = c_zero;
            next_wrap  = 1'b1;
          end else begin
            next_count = c_max;
          end
        end
        DIR_DOWN: begin
          if (!w_at_zero) begin
            next_count = count - c_one;
          end else if (SATURATE == 0) begin
            next_count = c_max;
            next_wrap  = 1'b1;
          end else begin
            next_count = c_zero;
          end
        end
        default: begin
          next_count = count;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_sync_counter.sv
`default_nettype none
// ============================================================================
// Module : param_sync_counter
// Brief  : WIDTH-bit modulo counter, up/down, load, wrap/saturate, bin/Gray q.
// Rev    : 1.0  initial release
// ============================================================================
module param_sync_counter
  import param_sync_counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          SATURATE  = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sync_clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             gray_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] count_bin,
  output logic             terminal,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;
  logic [WIDTH-1:0] w_q_next;

  counter_next_state #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_next_state (
    .count      (r_count),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .sync_clear (sync_clear),
    .next_count (w_next_count),
    .next_wrap  (w_next_wrap)
  );

  // q is coded from the next state so it lines up with count_bin.
  always_comb begin
    w_q_next = w_next_count;
    case (gray_sel)
      CODE_GRAY: w_q_next = WIDTH'(bin2gray(32'(w_next_count)));
      CODE_BIN:  w_q_next = w_next_count;
      default:   w_q_next = w_next_count;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count <= '0;
      r_q     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_q     <= w_q_next;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count_bin  = r_count;
  assign q          = r_q;
  assign q_bar      = ~r_q;
  assign wrap_pulse = r_wrap;

  // Live enable/up keep the cascade ripple-free into the next stage's enable.
  assign terminal = enable & (((up == DIR_UP)   & (r_count == c_max)) |
                              ((up == DIR_DOWN) & (r_count == '0)));

endmodule
`default_nettype wire

// File: tb/tb_param_sync_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_param_sync_counter
// Brief  : Three counter configurations driven in lockstep against a model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_param_sync_counter;

  logic       clock = 1'b0;
  logic       clear;
  logic       sync_clear;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] load_value;
  logic       gray_sel;

  // index 0: MAX 9 wrap, 1: MAX 9 saturate, 2: MAX 15 wrap
  logic [2:0][3:0] cnt_o;
  logic [2:0][3:0] q_o;
  logic [2:0][3:0] qb_o;
  logic [2:0]      wrap_o;
  logic [2:0]      term_o;

  int m_cnt  [3];
  int m_q    [3];
  int m_wrap [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  param_sync_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_a (
    .clock(clock), .clear(clear), .sync_clear(sync_clear), .enable(enable),
    .up(up), .load(load), .load_value(load_value), .gray_sel(gray_sel),
    .q(q_o[0]), .q_bar(qb_o[0]), .count_bin(cnt_o[0]),
    .terminal(term_o[0]), .wrap_pulse(wrap_o[0]));

  param_sync_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_b (
    .clock(clock), .clear(clear), .sync_clear(sync_clear), .enable(enable),
    .up(up), .load(load), .load_value(load_value), .gray_sel(gray_sel),
    .q(q_o[1]), .q_bar(qb_o[1]), .count_bin(cnt_o[1]),
    .terminal(term_o[1]), .wrap_pulse(wrap_o[1]));

  param_sync_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) dut_c (
    .clock(clock), .clear(clear), .sync_clear(sync_clear), .enable(enable),
    .up(up), .load(load), .load_value(load_value), .gray_sel(gray_sel),
    .q(q_o[2]), .q_bar(qb_o[2]), .count_bin(cnt_o[2]),
    .terminal(term_o[2]), .wrap_pulse(wrap_o[2]));

  function automatic int max_of(input int i);
    return (i == 2) ? 15 : 9;
  endfunction

  function automatic int sat_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic exp_term(input int i);
    return enable && ((up && m_cnt[i] == max_of(i)) || (!up && m_cnt[i] == 0));
  endfunction

  // Counting is arithmetic modulo MAX+1; saturation refuses the step that would wrap.
  function automatic void model_step(input logic sc, input logic ld, input int lv,
                                     input logic en, input logic u, input logic gs);
    for (int i = 0; i < 3; i++) begin
      int m;
      int crosses;
      m = max_of(i);
      m_wrap[i] = 0;
      if (sc) begin
        m_cnt[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (lv > m) ? m : lv;
      end else if (en) begin
        crosses = u ? int'(m_cnt[i] == m) : int'(m_cnt[i] == 0);
        if (crosses != 0 && sat_of(i) == 1) begin
          m_cnt[i] = m_cnt[i];
        end else begin
          m_cnt[i]  = (m_cnt[i] + (u ? 1 : m)) % (m + 1);
          m_wrap[i] = crosses;
        end
      end
      m_q[i] = gs ? gray_of(m_cnt[i]) : m_cnt[i];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_q[i] = 0; m_wrap[i] = 0;
    end
  endfunction

  task automatic drive(input logic sc, input logic ld, input logic [3:0] lv,
                       input logic en, input logic u, input logic gs);
    sync_clear = sc; load = ld; load_value = lv; enable = en; up = u; gray_sel = gs;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(sync_clear, load, int'(load_value), enable, up, gray_sel);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cnt_o[i] !== 4'd0 || q_o[i] !== 4'd0 || qb_o[i] !== 4'hF || wrap_o[i] !== 1'b0 || term_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got cnt=%0d q=%h qb=%h wrap=%b term=%b expected 0/0/f/0/0",
                 i, cnt_o[i], q_o[i], qb_o[i], wrap_o[i], term_o[i]);
      end
    end
    #1 clear = 1'b0;
  endtask

  task automatic test_count_up();
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int s = 0; s < 17; s++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (term_o[i] !== exp_term(i)) begin
          n_fail++;
          $display("FAIL up_term dut%0d step%0d: got %b expected %b", i, s, term_o[i], exp_term(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cnt_o[i] !== 4'(m_cnt[i]) || wrap_o[i] !== 1'(m_wrap[i]) || q_o[i] !== 4'(m_q[i])) begin
          n_fail++;
          $display("FAIL up_count dut%0d step%0d: got cnt=%0d wrap=%b q=%h expected cnt=%0d wrap=%0d q=%h",
                   i, s, cnt_o[i], wrap_o[i], q_o[i], m_cnt[i], m_wrap[i], m_q[i]);
        end
      end
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int s = 0; s < 12; s++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (term_o[i] !== exp_term(i)) begin
          n_fail++;
          $display("FAIL down_term dut%0d step%0d: got %b expected %b", i, s, term_o[i], exp_term(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cnt_o[i] !== 4'(m_cnt[i]) || wrap_o[i] !== 1'(m_wrap[i]) || qb_o[i] !== ~4'(m_q[i])) begin
          n_fail++;
          $display("FAIL down_count dut%0d step%0d: got cnt=%0d wrap=%b qb=%h expected cnt=%0d wrap=%0d qb=%h",
                   i, s, cnt_o[i], wrap_o[i], qb_o[i], m_cnt[i], m_wrap[i], ~4'(m_q[i]));
        end
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_cnt [3];
    // load 12 clamps on MAX 9; load+sync_clear clears; load+enable loads without counting
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0); exp_cnt = '{4'd9, 4'd9, 4'd12}; end
        1: begin drive(1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0); exp_cnt = '{4'd0, 4'd0, 4'd0}; end
        default: begin drive(1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0); exp_cnt = '{4'd6, 4'd6, 4'd6}; end
      endcase
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cnt_o[i] !== exp_cnt[i] || wrap_o[i] !== 1'b0 || cnt_o[i] !== 4'(m_cnt[i])) begin
          n_fail++;
          $display("FAIL load dut%0d case%0d: got cnt=%0d wrap=%b expected cnt=%0d wrap=0",
                   i, k, cnt_o[i], wrap_o[i], exp_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_gray();
    logic [3:0] prev;
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (q_o[2] !== 4'b0100) begin
      n_fail++;
      $display("FAIL gray_7 dut2: got %b expected 0100", q_o[2]);
    end
    for (int s = 0; s < 17; s++) begin
      prev = q_o[2];
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if ($countones(prev ^ q_o[2]) != 1 || q_o[2] !== 4'(m_q[2]) || qb_o[2] !== ~4'(m_q[2])) begin
        n_fail++;
        $display("FAIL gray_step step%0d: got q=%b qb=%b prev=%b expected q=%b one-bit change",
                 s, q_o[2], qb_o[2], prev, 4'(m_q[2]));
      end
      if (s == 0) begin
        n_cmp++;
        if (q_o[2] !== 4'b1100) begin
          n_fail++;
          $display("FAIL gray_8 dut2: got %b expected 1100", q_o[2]);
        end
      end
    end
    // switching coding while holding must wait for an edge
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_o[i] !== 4'(m_q[i])) begin
        n_fail++;
        $display("FAIL gray_hold_pre dut%0d: got %h expected %h", i, q_o[i], 4'(m_q[i]));
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_o[i] !== 4'(m_cnt[i]) || cnt_o[i] !== 4'(m_cnt[i])) begin
        n_fail++;
        $display("FAIL gray_hold_post dut%0d: got q=%h cnt=%0d expected %h", i, q_o[i], cnt_o[i], 4'(m_cnt[i]));
      end
    end
  endtask

  task automatic test_async_clear();
    drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #2 clear = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cnt_o[i] !== 4'd0 || q_o[i] !== 4'd0 || qb_o[i] !== 4'hF || wrap_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_clear dut%0d: got cnt=%0d q=%h qb=%h wrap=%b expected 0/0/f/0",
                 i, cnt_o[i], q_o[i], qb_o[i], wrap_o[i]);
      end
    end
    #2 clear = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cnt_o[i] !== 4'd1 || cnt_o[i] !== 4'(m_cnt[i])) begin
        n_fail++;
        $display("FAIL async_release dut%0d: got %0d expected 1", i, cnt_o[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (term_o[i] !== exp_term(i)) begin
          n_fail++;
          $display("FAIL rand_term dut%0d step%0d: got %b expected %b", i, s, term_o[i], exp_term(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cnt_o[i] !== 4'(m_cnt[i]) || wrap_o[i] !== 1'(m_wrap[i]) ||
            q_o[i] !== 4'(m_q[i]) || qb_o[i] !== ~4'(m_q[i])) begin
          n_fail++;
          $display("FAIL rand_state dut%0d step%0d: got cnt=%0d wrap=%b q=%h qb=%h expected cnt=%0d wrap=%0d q=%h",
                   i, s, cnt_o[i], wrap_o[i], q_o[i], qb_o[i], m_cnt[i], m_wrap[i], 4'(m_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_gray();
    test_async_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
